ps2_key_ctrl: RTL and testbench

- Sequencer between the PS/2 receiver byte FIFO and downstream consumers (seven-segment display, key-to-ASCII lookup).
- Pops scan-code bytes using the FIFO's ready/nextdata_n handshake and folds the E0 (extended) and F0 (break) prefixes into single key events.
- Tracks the currently held key, separates typematic repeats from new presses, and counts distinct presses.

---
 rtl/ps2_key_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 scan-code sequencer: pops receiver FIFO bytes and folds prefixes into key events
module ps2_key_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data_in,
  input  logic             overflow,
  input  logic             err_clr,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic             pressing,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err_flag
);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_ER0 = 8'h00;
  localparam logic [7:0] CODE_ER1 = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [7:0]       byte_r, byte_n;
  logic             ext_pend, ext_pend_n;
  logic             brk_pend, brk_pend_n;
  logic             nextdata_n_n;
  logic             key_valid_n;
  logic [7:0]       key_code_n;
  logic             key_ext_n;
  logic             key_release_n;
  logic             key_repeat_n;
  logic             pressing_n;
  logic [7:0]       held_code_n;
  logic             held_ext_n;
  logic [CNT_W-1:0] press_cnt_n;
  logic             err_flag_n;
  logic             err_byte;
  logic             held_match;

  // The decoded byte names the held key when both extended bit and code agree.
  assign held_match = pressing && (held_ext == ext_pend) && (held_code == byte_r);

  // Next-state and next-output logic: latch in IDLE, pop and decode in ACK, settle in GAP.
  always_comb begin
    state_n       = state;
    byte_n        = byte_r;
    ext_pend_n    = ext_pend;
    brk_pend_n    = brk_pend;
    nextdata_n_n  = 1'b1;
    key_valid_n   = 1'b0;
    key_code_n    = key_code;
    key_ext_n     = key_ext;
    key_release_n = key_release;
    key_repeat_n  = key_repeat;
    pressing_n    = pressing;
    held_code_n   = held_code;
    held_ext_n    = held_ext;
    press_cnt_n   = press_cnt;
    err_byte      = 1'b0;

    case (state)
      IDLE: begin
        if (ready) begin
          byte_n       = data_in;
          nextdata_n_n = 1'b0;
          state_n      = ACK;
        end
      end
      ACK: begin
        state_n = GAP;
        if (byte_r == CODE_EXT) begin
          ext_pend_n = 1'b1;
        end else if (byte_r == CODE_BRK) begin
          brk_pend_n = 1'b1;
        end else if (byte_r == CODE_ER0 || byte_r == CODE_ER1) begin
          err_byte   = 1'b1;
          ext_pend_n = 1'b0;
          brk_pend_n = 1'b0;
        end else begin
          key_valid_n   = 1'b1;
          key_code_n    = byte_r;
          key_ext_n     = ext_pend;
          key_release_n = brk_pend;
          key_repeat_n  = 1'b0;
          ext_pend_n    = 1'b0;
          brk_pend_n    = 1'b0;
          if (!brk_pend) begin
            if (held_match) begin
              key_repeat_n = 1'b1;
            end else begin
              pressing_n  = 1'b1;
              held_code_n = byte_r;
              held_ext_n  = ext_pend;
              press_cnt_n = press_cnt + CNT_W'(1);
            end
          end else if (held_match) begin
            pressing_n  = 1'b0;
            held_code_n = 8'h00;
            held_ext_n  = 1'b0;
          end
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A set condition in the same cycle as err_clr keeps the flag set.
    if (overflow || err_byte) begin
      err_flag_n = 1'b1;
    end else if (err_clr) begin
      err_flag_n = 1'b0;
    end else begin
      err_flag_n = err_flag;
    end
  end

  // State and output registers; reset aborts any byte in flight and drops the pop strobe at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      byte_r      <= 8'h00;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      nextdata_n  <= 1'b1;
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      pressing    <= 1'b0;
      held_code   <= 8'h00;
      held_ext    <= 1'b0;
      press_cnt   <= '0;
      err_flag    <= 1'b0;
    end else begin
      state       <= state_n;
      byte_r      <= byte_n;
      ext_pend    <= ext_pend_n;
      brk_pend    <= brk_pend_n;
      nextdata_n  <= nextdata_n_n;
      key_valid   <= key_valid_n;
      key_code    <= key_code_n;
      key_ext     <= key_ext_n;
      key_release <= key_release_n;
      key_repeat  <= key_repeat_n;
      pressing    <= pressing_n;
      held_code   <= held_code_n;
      held_ext    <= held_ext_n;
      press_cnt   <= press_cnt_n;
      err_flag    <= err_flag_n;
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - scoreboard bench for ps2_key_ctrl
`timescale 1ns/1ps
module tb_ps2_key_ctrl;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             ready;
  logic [7:0]       data_in;
  logic             overflow;
  logic             err_clr;
  logic             nextdata_n;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_release;
  logic             key_repeat;
  logic             pressing;
  logic [7:0]       held_code;
  logic             held_ext;
  logic [CNT_W-1:0] press_cnt;
  logic             err_flag;

  typedef struct packed {
    logic [7:0]       code;
    logic             ext;
    logic             rel;
    logic             rep;
    logic             prs;
    logic [7:0]       hc;
    logic             he;
    logic [CNT_W-1:0] cnt;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  pops  = 0;
  int  kvs   = 0;

  ps2_key_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ready(ready), .data_in(data_in),
    .overflow(overflow), .err_clr(err_clr), .nextdata_n(nextdata_n),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_release(key_release), .key_repeat(key_repeat), .pressing(pressing),
    .held_code(held_code), .held_ext(held_ext), .press_cnt(press_cnt),
    .err_flag(err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop strobe counter and event scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    ev_t obs;
    ev_t exp_ev;
    if (rst && !nextdata_n) pops++;
    if (key_valid) begin
      kvs++;
      obs = '{key_code, key_ext, key_release, key_repeat, pressing, held_code, held_ext, press_cnt};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event got=%h required=none", obs);
      end else begin
        exp_ev = sb.pop_front();
        if (obs !== exp_ev) begin
          bad++;
          $display("FAIL event got={code,ext,rel,rep,prs,hc,he,cnt}=%h required=%h", obs, exp_ev);
        end
      end
    end
  end

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic rel,
                           input logic rep, input logic prs, input logic [7:0] hc,
                           input logic he, input logic [CNT_W-1:0] cnt);
    sb.push_back('{code, ext, rel, rep, prs, hc, he, cnt});
  endtask

  // Present a byte at the FIFO head and wait until the DUT pops it.
  task automatic push_byte(input logic [7:0] b);
    bit seen = 0;
    data_in = b;
    ready   = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (!nextdata_n) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL pop_timeout byte=%h got=none required=pop", b);
    end
  endtask

  task automatic idle(input int n);
    ready   = 1'b0;
    data_in = 8'h5A;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b0; ready = 1'b0; overflow = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    pops = 0;
    kvs  = 0;
  endtask

  task automatic check_counts(input string name, input int exp_pops, input int exp_kvs);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_pending got=%0d required=0", name, sb.size());
    end
    total++;
    if (pops != exp_pops) begin
      bad++;
      $display("FAIL %s_pops got=%0d required=%0d", name, pops, exp_pops);
    end
    total++;
    if (kvs != exp_kvs) begin
      bad++;
      $display("FAIL %s_events got=%0d required=%0d", name, kvs, exp_kvs);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; ready = 1'b0; data_in = 8'h00; overflow = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({nextdata_n, key_valid, key_code, key_ext, key_release, key_repeat,
         pressing, held_code, held_ext, press_cnt, err_flag} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, {CNT_W{1'b0}}, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got nd=%b kv=%b kc=%h hc=%h cnt=%0d err=%b required nd=1 rest=0",
               nextdata_n, key_valid, key_code, held_code, press_cnt, err_flag);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_make_break;
    apply_reset();
    expect_ev(8'h1C, 0, 0, 0, 1, 8'h1C, 0, 2'd1);
    push_byte(8'h1C);
    push_byte(8'hF0);
    expect_ev(8'h1C, 0, 1, 0, 0, 8'h00, 0, 2'd1);
    push_byte(8'h1C);
    idle(5);
    check_counts("make_break", 3, 2);
  endtask

  task automatic test_repeat;
    apply_reset();
    expect_ev(8'h1C, 0, 0, 0, 1, 8'h1C, 0, 2'd1);
    expect_ev(8'h1C, 0, 0, 1, 1, 8'h1C, 0, 2'd1);
    expect_ev(8'h1C, 0, 0, 1, 1, 8'h1C, 0, 2'd1);
    for (int i = 0; i < 3; i++) push_byte(8'h1C);
    idle(5);
    check_counts("repeat", 3, 3);
  endtask

  task automatic test_extended;
    apply_reset();
    expect_ev(8'h75, 1, 0, 0, 1, 8'h75, 1, 2'd1);
    expect_ev(8'h75, 1, 1, 0, 0, 8'h00, 0, 2'd1);
    push_byte(8'hE0); push_byte(8'h75);
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    idle(5);
    check_counts("extended", 5, 2);
    // Break prefix before extended prefix, and a non-extended 75 is a different key
    expect_ev(8'h75, 0, 0, 0, 1, 8'h75, 0, 2'd2);
    expect_ev(8'h75, 1, 1, 0, 1, 8'h75, 0, 2'd2);
    push_byte(8'h75);
    push_byte(8'hF0); push_byte(8'hE0); push_byte(8'h75);
    idle(5);
    check_counts("brk_then_ext", 9, 4);
  endtask

  task automatic test_replace;
    apply_reset();
    expect_ev(8'h1C, 0, 0, 0, 1, 8'h1C, 0, 2'd1);
    expect_ev(8'h32, 0, 0, 0, 1, 8'h32, 0, 2'd2);
    expect_ev(8'h1C, 0, 1, 0, 1, 8'h32, 0, 2'd2);
    push_byte(8'h1C); push_byte(8'h32);
    push_byte(8'hF0); push_byte(8'h1C);
    idle(5);
    check_counts("replace", 4, 3);
  endtask

  task automatic test_errors;
    apply_reset();
    overflow = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    total++;
    if (err_flag !== 1'b1) begin
      bad++;
      $display("FAIL err_set_wins got=%b required=1", err_flag);
    end
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (err_flag !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b required=0", err_flag);
    end
    push_byte(8'hFF);
    idle(4);
    total++;
    if (err_flag !== 1'b1) begin
      bad++;
      $display("FAIL err_byte got=%b required=1", err_flag);
    end
    // Error byte discards a pending extended prefix
    expect_ev(8'h1C, 0, 0, 0, 1, 8'h1C, 0, 2'd1);
    push_byte(8'hE0); push_byte(8'h00); push_byte(8'h1C);
    idle(5);
    check_counts("errors", 4, 1);
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    apply_reset();
    data_in = 8'hE0;
    ready   = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (!nextdata_n) seen = 1;
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if (!seen || nextdata_n !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pop got seen=%0d nd=%b required seen=1 nd=1", seen, nextdata_n);
    end
    ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pops = 0;
    kvs  = 0;
    expect_ev(8'h1C, 0, 0, 0, 1, 8'h1C, 0, 2'd1);
    push_byte(8'h1C);
    idle(5);
    check_counts("reset_mid", 1, 1);
  endtask

  task automatic test_back_to_back_wrap;
    logic [7:0] codes [4];
    codes[0] = 8'h11; codes[1] = 8'h22; codes[2] = 8'h33; codes[3] = 8'h44;
    apply_reset();
    for (int i = 0; i < 4; i++)
      expect_ev(codes[i], 0, 0, 0, 1, codes[i], 0, CNT_W'(i + 1));
    for (int i = 0; i < 4; i++) push_byte(codes[i]);
    idle(5);
    check_counts("wrap", 4, 4);
    total++;
    if (press_cnt !== '0) begin
      bad++;
      $display("FAIL wrap_cnt got=%0d required=0", press_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_repeat();
    test_extended();
    test_replace();
    test_errors();
    test_reset_mid();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
